stall_arbiter: RTL and testbench

STALL_ARBITER -- requirements
Module: stall_arbiter

---
 rtl/stall_arbiter.sv | 90 +++++++++
 tb/tb_stall_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stall_arbiter.sv
// stall_arbiter: round-robin arbiter giving two pipelines one shared multi-cycle resource,
// with per-pipeline stall, flush-driven cancel and a sticky watchdog on the resource.
module stall_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic              res_start,
  output logic [DATA_W-1:0] res_operand,
  input  logic              res_done,
  input  logic [DATA_W-1:0] res_result,
  output logic [1:0]        resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              stall_1,
  output logic              stall_2,
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state, state_nxt;
  logic owner, prio, cancel, grant, owner_flush, timed_out;
  logic [1:0] eff_req;
  logic [CW-1:0] cnt;
  assign eff_req     = req & ~{flush_2, flush_1};
  assign grant       = (&eff_req) ? prio : eff_req[1];
  assign owner_flush = owner ? flush_2 : flush_1;
  assign timed_out   = cnt == CW'(TIMEOUT - 1);
  assign stall_1     = req[0] & ~flush_1 & ~resp_valid[0];
  assign stall_2     = req[1] & ~flush_2 & ~resp_valid[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt  = state;
    res_start  = 1'b0;
    resp_valid = 2'b00;
    case (state)
      S_IDLE:  state_nxt = |eff_req ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        res_start = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT:  state_nxt = res_done ? S_RESP : (timed_out ? S_IDLE : S_WAIT);
      S_RESP:  begin
        resp_valid = cancel ? 2'b00 : (owner ? 2'b10 : 2'b01);
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
  // cancel is cleared on every path back to idle so a stale flush never leaks into the next grant
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner       <= 1'b0;
      prio        <= 1'b0;
      cancel      <= 1'b0;
      cnt         <= '0;
      res_operand <= '0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|eff_req) begin
          owner       <= grant;
          prio        <= ~grant;
          res_operand <= grant ? req_data_2 : req_data_1;
        end
        S_ISSUE: begin
          cnt <= '0;
          if (owner_flush) cancel <= 1'b1;
        end
        S_WAIT: begin
          if (owner_flush) cancel <= 1'b1;
          if (res_done) resp_data <= res_result;
          else if (timed_out) begin
            timeout_err <= 1'b1;
            cancel      <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        S_RESP: cancel <= 1'b0;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_stall_arbiter.sv
// tb_stall_arbiter: directed scenarios plus a random run, checked every cycle against a
// transaction-level model of the arbiter, with literal expectations pinning key moments.
module tb_stall_arbiter;
  localparam int DW = 32;
  localparam int TO = 16;
  logic clk = 0, reset = 0;
  logic [1:0] req = 0;
  logic [DW-1:0] req_data_1 = 0, req_data_2 = 0, res_result = 0;
  logic flush_1 = 0, flush_2 = 0, res_done = 0;
  logic res_start, stall_1, stall_2, timeout_err;
  logic [DW-1:0] res_operand, resp_data;
  logic [1:0] resp_valid;
  int checks = 0, errors = 0;

  stall_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data_1(req_data_1), .req_data_2(req_data_2),
    .flush_1(flush_1), .flush_2(flush_2), .res_start(res_start), .res_operand(res_operand),
    .res_done(res_done), .res_result(res_result), .resp_valid(resp_valid), .resp_data(resp_data),
    .stall_1(stall_1), .stall_2(stall_2), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one operation is a transaction with a phase (issue, waiting, response).
  bit m_busy = 0, m_issue = 0, m_resp = 0, m_cancel = 0, m_owner = 0, m_prio = 0, m_err = 0;
  logic [DW-1:0] m_op = 0, m_data = 0;
  int m_waited = 0;
  int starve [2] = '{0, 0};
  always @(posedge clk or negedge reset) begin
    logic [1:0] er;
    bit g;
    if (!reset) begin
      m_busy = 0; m_issue = 0; m_resp = 0; m_cancel = 0; m_owner = 0; m_prio = 0; m_err = 0;
      m_op = 0; m_data = 0; m_waited = 0; starve[0] = 0; starve[1] = 0;
    end else if (m_resp) begin
      m_resp = 0; m_busy = 0; m_cancel = 0;
    end else if (!m_busy) begin
      er = req & ~{flush_2, flush_1};
      if (er != 0) begin
        if (er == 2'b11) g = m_prio;
        else if (er == 2'b01) g = 0;
        else g = 1;
        m_owner = g; m_prio = !g; m_op = g ? req_data_2 : req_data_1;
        m_busy = 1; m_issue = 1;
        starve[g] = 0;
        if (er[!g]) starve[!g] = starve[!g] + 1;
      end
    end else begin
      if (m_owner ? flush_2 : flush_1) m_cancel = 1;
      if (m_issue) begin
        m_issue = 0; m_waited = 0;
      end else if (res_done) begin
        m_data = res_result; m_resp = 1;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited == TO) begin
          m_err = 1; m_busy = 0; m_cancel = 0;
        end
      end
    end
  end

  logic prev_start = 0;
  always @(negedge clk) begin
    logic [1:0] exp_rv;
    exp_rv = (m_resp && !m_cancel) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("res_start", res_start, m_issue);
    chk("res_operand", res_operand, m_op);
    chk("resp_valid", resp_valid, exp_rv);
    chk("resp_data", resp_data, m_data);
    chk("stall_1", stall_1, req[0] & ~flush_1 & ~exp_rv[0]);
    chk("stall_2", stall_2, req[1] & ~flush_2 & ~exp_rv[1]);
    chk("timeout_err", timeout_err, m_err);
    chk("resp_both", resp_valid == 2'b11, 0);
    chk("start_b2b", res_start & prev_start, 0);
    chk("starve", starve[0] > 2 || starve[1] > 2, 0);
    prev_start = res_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0; req = 0; flush_1 = 0; flush_2 = 0; res_done = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  initial begin
    logic [DW-1:0] exp_ops [4];
    bit found;
    exp_ops = '{32'h100, 32'h200, 32'h100, 32'h200};
    do_reset();
    @(negedge clk);
    chk("rst_operand", res_operand, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_err", timeout_err, 0);
    // single request, result two cycles after start
    req = 2'b01; req_data_1 = 32'h11; tick();
    @(negedge clk);
    chk("s1_start", res_start, 1);
    chk("s1_operand", res_operand, 32'h11);
    chk("s1_stall_issue", stall_1, 1);
    tick(); tick();
    res_done = 1; res_result = 32'hAA;
    tick(); res_done = 0;
    @(negedge clk);
    chk("s1_valid", resp_valid, 2'b01);
    chk("s1_data", resp_data, 32'hAA);
    chk("s1_stall_resp", stall_1, 0);
    req = 0; tick();
    // both requesting from reset alternate 1,2,1,2
    do_reset();
    req = 2'b11; req_data_1 = 32'h100; req_data_2 = 32'h200; res_done = 1; res_result = 32'h5;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      for (int n = 0; n < 10 && !found; n++) begin
        @(negedge clk);
        if (res_start) found = 1;
      end
      chk("s2_grant_seen", found, 1);
      chk("s2_order", res_operand, exp_ops[k]);
      if (k % 2 == 0) chk("s2_stall_2", stall_2, 1);
    end
    req = 0; res_done = 0; tick();
    // owner flushed while waiting: no strobe, next grant is normal
    do_reset();
    req = 2'b01; req_data_1 = 32'h22; tick();
    tick(); flush_1 = 1;
    tick(); flush_1 = 0;
    tick(); res_done = 1; res_result = 32'h55; req_data_1 = 32'h33;
    tick(); res_done = 0;
    @(negedge clk);
    chk("s3_cancel_valid", resp_valid, 0);
    tick(); tick();
    @(negedge clk);
    chk("s3_regrant", res_start, 1);
    chk("s3_operand", res_operand, 32'h33);
    res_done = 1;
    tick(); tick(); res_done = 0;
    @(negedge clk);
    chk("s3_valid", resp_valid, 2'b01);
    chk("s3_data", resp_data, 32'h55);
    req = 0; tick();
    // resource never answers: watchdog fires after TIMEOUT waiting cycles and sticks
    do_reset();
    req = 2'b10; req_data_2 = 32'h44; tick(); req = 0;
    repeat (TO) tick();
    @(negedge clk);
    chk("s4_err_before", timeout_err, 0);
    tick();
    @(negedge clk);
    chk("s4_err_set", timeout_err, 1);
    chk("s4_no_valid", resp_valid, 0);
    repeat (5) tick();
    req = 2'b01; res_done = 1; tick(); tick(); tick(); res_done = 0; req = 0;
    @(negedge clk);
    chk("s4_later_valid", resp_valid, 2'b01);
    chk("s4_err_sticky", timeout_err, 1);
    tick();
    // reset mid-wait, then a late done
    do_reset();
    req = 2'b01; req_data_1 = 32'h66; tick(); tick(); tick();
    #2 reset = 0;
    #1;
    chk("s5_start", res_start, 0);
    chk("s5_operand", res_operand, 0);
    chk("s5_valid", resp_valid, 0);
    chk("s5_stall", stall_1, 1);
    req = 0;
    @(posedge clk); #1 reset = 1; res_done = 1; res_result = 32'h77;
    tick(); res_done = 0;
    @(negedge clk);
    chk("s5_late_valid", resp_valid, 0);
    chk("s5_late_data", resp_data, 0);
    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req = 2'($urandom);
      flush_1 = ($urandom_range(7) == 0);
      flush_2 = ($urandom_range(7) == 0);
      res_done = ($urandom_range(2) == 0);
      res_result = $urandom; req_data_1 = $urandom; req_data_2 = $urandom;
      tick();
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
